// File: rtl/mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mul_rr_sched
// Function : round-robin sharing of one iterative multiplier among N clients
// Revision : 1.0
// ============================================================================
module mul_rr_sched #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_bi,
    input  logic [N*W-1:0]   a_bi,
    input  logic [N*W-1:0]   b_bi,
    output logic [N-1:0]     ack_bo,
    output logic [N-1:0]     done_bo,
    output logic [N-1:0]     err_bo,
    output logic [2*W-1:0]   y_bo,
    output logic             busy_o,
    output logic             mul_start_o,
    output logic [W-1:0]     mul_a_bo,
    output logic [W-1:0]     mul_b_bo,
    input  logic             mul_busy_i,
    input  logic [2*W-1:0]   mul_y_bi
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     done_q, done_d;
    logic [N-1:0]     err_q, err_d;
    logic [2*W-1:0]   y_q, y_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [W-1:0]     mul_a_q, mul_a_d;
    logic [W-1:0]     mul_b_q, mul_b_d;

    logic             found;
    logic [PTR_W-1:0] gnt;

    // Rotating search starting just after the last owner, so it sees lowest priority.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        gnt   = ptr_q;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PTR_W'(idx);
            if (!found && req_bi[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        y_d     = y_q;
        start_d = 1'b0;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d   = gnt;
                    mul_a_d = a_bi[int'(gnt)*W +: W];
                    mul_b_d = b_bi[int'(gnt)*W +: W];
                    ack_d   = N'(1) << gnt;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Abort lands done/err exactly TIMEOUT+2 cycles after the ack pulse.
                if (mul_busy_i) begin
                    state_d = S_RUN;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    y_d     = '0;
                    done_d  = N'(1) << ptr_q;
                    err_d   = N'(1) << ptr_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!mul_busy_i) begin
                    y_d     = mul_y_bi;
                    done_d  = N'(1) << ptr_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(N - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign ack_bo      = ack_q;
    assign done_bo     = done_q;
    assign err_bo      = err_q;
    assign y_bo        = y_q;
    assign busy_o      = busy_q;
    assign mul_start_o = start_q;
    assign mul_a_bo    = mul_a_q;
    assign mul_b_bo    = mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_rr_sched
// Function : scoreboard bench for mul_rr_sched with an 8-cycle multiplier model
// Revision : 1.0
// ============================================================================
module tb_mul_rr_sched;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_bi, b_bi;
    logic [N-1:0]     ack_bo, done_bo, err_bo;
    logic [2*W-1:0]   y_bo;
    logic             busy_o, mul_start;
    logic [W-1:0]     mul_a, mul_b;
    logic             mbusy = 1'b0;
    logic [2*W-1:0]   mprod = '0;
    logic [3:0]       mleft = '0;
    logic             mul_tie0;

    always #5 clk = ~clk;

    mul_rr_sched #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_bi      (req),
        .a_bi        (a_bi),
        .b_bi        (b_bi),
        .ack_bo      (ack_bo),
        .done_bo     (done_bo),
        .err_bo      (err_bo),
        .y_bo        (y_bo),
        .busy_o      (busy_o),
        .mul_start_o (mul_start),
        .mul_a_bo    (mul_a),
        .mul_b_bo    (mul_b),
        .mul_busy_i  (mbusy),
        .mul_y_bi    (mprod)
    );

    // Iterative multiplier stand-in: busy for 8 cycles after the start strobe.
    always @(posedge clk) begin
        if (mul_start && !mul_tie0) begin
            mbusy <= 1'b1;
            mleft <= 4'd7;
            mprod <= 16'(mul_a) * 16'(mul_b);
        end else if (mbusy) begin
            if (mleft == 0) mbusy <= 1'b0;
            else            mleft <= mleft - 1'b1;
        end
    end

    typedef struct {
        int          idx;
        logic [15:0] y;
        bit          err;
    } exp_t;

    exp_t sb_q[$];
    int   ack_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_ack = -1;
    bit   chk_spacing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops expectations whenever the DUT pulses ack or done.
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (ack_bo != '0) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack_bo), 0);
                end else begin
                    int g;
                    g = ack_q.pop_front();
                    check("ack_grant", 32'(ack_bo), 32'(1) << g);
                    if (chk_spacing && last_ack >= 0)
                        check("ack_spacing", 32'(cyc - last_ack), 12);
                end
                last_ack = cyc;
            end
            if (done_bo != '0) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'(done_bo), 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("done_owner", 32'(done_bo), 32'(1) << e.idx);
                    check("err_flag", 32'(err_bo), e.err ? (32'(1) << e.idx) : 32'd0);
                    check("y_value", 32'(y_bo), 32'(e.y));
                    check("done_latency", 32'(cyc - last_ack), e.err ? TIMEOUT + 2 : 10);
                end
            end else begin
                if (err_bo != '0) check("err_without_done", 32'(err_bo), 0);
            end
        end
    end

    task automatic set_op(input int k, input logic [7:0] av, input logic [7:0] bv);
        a_bi[k*W +: W] = av;
        b_bi[k*W +: W] = bv;
    endtask

    task automatic wait_ack(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_bo[k] !== 1'b1 && n < 100);
        if (ack_bo[k] !== 1'b1) check("ack_timeout", 32'(k), 32'(k) + 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || ack_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || ack_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size() + ack_q.size()), 0);
            sb_q.delete();
            ack_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic single(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] yexp, input bit eexp);
        set_op(k, av, bv);
        ack_q.push_back(k);
        sb_q.push_back('{k, yexp, eexp});
        req[k] = 1'b1;
        wait_ack(k);
        req[k] = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni   = 1'b0;
        req      = '0;
        a_bi     = '0;
        b_bi     = '0;
        mul_tie0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ack", 32'(ack_bo), 0);
        check("rst_done", 32'(done_bo), 0);
        check("rst_start", 32'(mul_start), 0);
        check("rst_y", 32'(y_bo), 0);
        rst_ni = 1'b1;
        @(negedge clk);

        // T2: single request
        single(2, 8'd13, 8'd11, 16'd143, 1'b0);
        check("idle_after_done", 32'(busy_o), 0);

        // T1: reset while the multiplier is running; the operation must vanish
        set_op(1, 8'd3, 8'd4);
        ack_q.push_back(1);
        req[1] = 1'b1;
        wait_ack(1);
        req[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_y", 32'(y_bo), 0);
        check("midrst_start", 32'(mul_start), 0);
        check("midrst_mula", 32'(mul_a), 0);
        check("midrst_mulb", 32'(mul_b), 0);
        check("midrst_done", 32'(done_bo), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_idle", 32'(busy_o), 0);

        // T3: all requesting continuously, pointer restarted by reset
        for (int k = 0; k < N; k++) set_op(k, 8'(k + 2), 8'(k + 10));
        ack_q = '{0, 1, 2, 3, 0};
        sb_q.push_back('{0, 16'd20, 1'b0});
        sb_q.push_back('{1, 16'd33, 1'b0});
        sb_q.push_back('{2, 16'd48, 1'b0});
        sb_q.push_back('{3, 16'd65, 1'b0});
        sb_q.push_back('{0, 16'd20, 1'b0});
        last_ack    = -1;
        chk_spacing = 1'b1;
        req = 4'b1111;
        wait_ack(0);
        wait_ack(1);
        wait_ack(2);
        wait_ack(3);
        wait_ack(0);
        req = '0;
        drain();
        chk_spacing = 1'b0;

        // T4: pointer wrap from 3 with requesters 0 and 3
        single(3, 8'd5, 8'd13, 16'd65, 1'b0);
        ack_q = '{0, 3};
        sb_q.push_back('{0, 16'd20, 1'b0});
        sb_q.push_back('{3, 16'd65, 1'b0});
        req = 4'b1001;
        wait_ack(0);
        wait_ack(3);
        req = '0;
        drain();

        // T5: operand extremes
        single(1, 8'd255, 8'd255, 16'd65025, 1'b0);
        single(0, 8'd0, 8'd200, 16'd0, 1'b0);

        // T6: multiplier never goes busy, then recovers
        mul_tie0 = 1'b1;
        single(2, 8'd5, 8'd6, 16'd0, 1'b1);
        mul_tie0 = 1'b0;
        single(2, 8'd7, 8'd9, 16'd63, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
